// File: rtl/fifo_rd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_rd_ctrl : async FIFO read side, Gray sync + FWFT 2-entry out queue  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  rempty,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH+1:0] rd_level
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int LW = ADDR_WIDTH + 2;

  logic [PW-1:0]         rq1;
  logic [PW-1:0]         rq2_wptr;
  logic [PW-1:0]         rbin;
  logic [PW-1:0]         rbin_next;
  logic [PW-1:0]         rgray_next;
  logic [PW-1:0]         wbin_sync;
  logic [PW-1:0]         mem_words;
  logic [LW-1:0]         level_next;
  logic                  inflight;
  logic                  capture;
  logic                  pop;
  logic                  fetch;
  logic [1:0]            count;
  logic [1:0]            count_next;
  logic [2:0]            committed;
  logic [DATA_WIDTH-1:0] q1;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Two-flop synchronizer; nothing else samples the raw write pointer.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq1      <= '0;
      rq2_wptr <= '0;
    end else begin
      rq1      <= wptr_gray;
      rq2_wptr <= rq1;
    end
  end

  assign pop       = rd_valid & rd_ready;
  assign capture   = inflight;
  // Words already owed to the queue after this cycle's pop; never exceed two.
  assign committed = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign fetch     = ~rempty & (committed < 3'd2);

  assign rbin_next  = rbin + {{(PW-1){1'b0}}, fetch};
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  assign raddr      = rbin[ADDR_WIDTH-1:0];

  always_comb begin
    count_next = count;
    case ({capture, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  assign wbin_sync  = gray2bin(rq2_wptr);
  assign mem_words  = wbin_sync - rbin_next;
  assign level_next = {1'b0, mem_words}
                    + {{(LW-1){1'b0}}, fetch}
                    + {{(LW-2){1'b0}}, count_next};

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      rempty    <= 1'b1;
      inflight  <= 1'b0;
      rd_level  <= '0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= rgray_next;
      rempty    <= (rgray_next == rq2_wptr);
      inflight  <= fetch;
      rd_level  <= level_next;
    end
  end

  // rd_data is the queue head; q1 holds the second word when count is two.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      count    <= 2'd0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      q1       <= '0;
    end else begin
      count    <= count_next;
      rd_valid <= (count_next != 2'd0);
      case ({capture, pop})
        2'b10: begin
          if (count == 2'd0) rd_data <= mem_rd_data;
          else               q1      <= mem_rd_data;
        end
        2'b01: rd_data <= q1;
        2'b11: begin
          if (count == 2'd1) begin
            rd_data <= mem_rd_data;
          end else begin
            rd_data <= q1;
            q1      <= mem_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow : assert property (@(posedge rclk) disable iff (!rrst_n)
    !(capture && !pop && (count == 2'd2)));

  a_committed_bound : assert property (@(posedge rclk) disable iff (!rrst_n)
    (({1'b0, count} + {2'b00, inflight}) <= 3'd2));

endmodule
`default_nettype wire
